// File: rtl/lanes_pkg.sv
// Shared constants, lane entry payload and horizontal-motion helper for obstacle_lanes.
package lanes_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned LANE_SHIFT    = 6;
  localparam int unsigned LANE_HEIGHT   = 64;
  localparam int unsigned X_W           = 10;
  localparam int unsigned SPEED_W       = 2;
  localparam int unsigned LFSR_W        = 16;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic               dir;
    logic [SPEED_W-1:0] speed;
  } lane_t;

  // One frame of horizontal motion with wrap-around at the screen edges.
  function automatic lane_t lane_move(lane_t l);
    lane_t        m;
    logic [X_W:0] sum;
    m   = l;
    sum = {1'b0, l.x} + (X_W+1)'(l.speed);
    if (l.speed != '0) begin
      if (l.dir) begin
        m.x = (sum >= (X_W+1)'(SCREEN_WIDTH)) ? X_W'(sum - (X_W+1)'(SCREEN_WIDTH)) : X_W'(sum);
      end else begin
        m.x = (l.x < X_W'(l.speed)) ? X_W'(l.x + X_W'(SCREEN_WIDTH) - X_W'(l.speed))
                                    : X_W'(l.x - X_W'(l.speed));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/obstacle_lanes_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/obstacle_lanes.sv
// Scrolling car-lane field with per-pixel car render and sticky collision flag.
// Optional collision logic: define OBSTACLE_LANES_COLLISION_EN.
module obstacle_lanes
  import lanes_pkg::*;
#(
  parameter int unsigned NUM_LANES   = (SCREEN_HEIGHT + LANE_HEIGHT - 1) / LANE_HEIGHT + 1,
  parameter int unsigned CAR_WIDTH   = 40,
  parameter int unsigned SCROLL_STEP = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_followers,
  input  logic       frame_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       player_on,
  output logic       car_on,
  output logic       hit,
  output logic [5:0] lane_offset
);

  localparam int unsigned SEL_W = 4;

  logic [LFSR_W-1:0] lfsr;
  lane_t             lanes_q [NUM_LANES];
  lane_t             lanes_d [NUM_LANES];
  lane_t             moved   [NUM_LANES];
  lane_t             spawn;
  lane_t             sel;
  logic [X_W-1:0]    r;
  logic [6:0]        offset_sum;
  logic [5:0]        offset_d;
  logic              rotate;
  logic [10:0]       ly;
  logic [SEL_W-1:0]  lane_sel;
  logic [10:0]       px;
  logic [10:0]       xs;
  logic [10:0]       xe;
  logic              car_hit_c;
  logic              unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Motion first, then rotation shifts the moved entries and drops in an unmoved spawn.
  always_comb begin
    offset_sum = 7'(lane_offset) + 7'(SCROLL_STEP);
    rotate     = move_followers && (offset_sum >= 7'(LANE_HEIGHT));
    offset_d   = lane_offset;
    if (rotate) begin
      offset_d = '0;
    end else if (move_followers) begin
      offset_d = offset_sum[5:0];
    end

    r           = lfsr[12:3];
    spawn.speed = lfsr[1:0];
    spawn.dir   = lfsr[2];
    spawn.x     = (r >= X_W'(SCREEN_WIDTH)) ? X_W'(r - X_W'(512)) : r;

    for (int i = 0; i < NUM_LANES; i++) begin
      moved[i]   = frame_tick ? lane_move(lanes_q[i]) : lanes_q[i];
      lanes_d[i] = moved[i];
    end
    if (rotate) begin
      lanes_d[0] = spawn;
      for (int i = 1; i < NUM_LANES; i++) begin
        lanes_d[i] = moved[i-1];
      end
    end
  end

  // Render lookup: map the pixel row to a lane, then test the car span without wrap.
  always_comb begin
    ly       = 11'(pix_y) + 11'(LANE_HEIGHT) - 11'(lane_offset);
    lane_sel = ly[LANE_SHIFT +: SEL_W];
    sel      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_sel == SEL_W'(i)) begin
        sel = lanes_q[i];
      end
    end
    px        = {1'b0, pix_x};
    xs        = {1'b0, sel.x};
    xe        = xs + 11'(CAR_WIDTH);
    car_hit_c = (sel.speed != '0) && (px >= xs) && (px < xe);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_offset <= '0;
      car_on      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      lane_offset <= offset_d;
      car_on      <= car_hit_c;
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= lanes_d[i];
      end
    end
  end

`ifdef OBSTACLE_LANES_COLLISION_EN
  logic player_d;

  // player_on is delayed to line up with the registered car_on.
  always_ff @(posedge clk) begin
    if (reset) begin
      player_d <= 1'b0;
      hit      <= 1'b0;
    end else begin
      player_d <= player_on;
      if (car_on && player_d) begin
        hit <= 1'b1;
      end
    end
  end

  assign unused_bits = ^{lfsr[15:13], ly[10], ly[LANE_SHIFT-1:0]};
`else
  assign hit         = 1'b0;
  assign unused_bits = ^{player_on, lfsr[15:13], ly[10], ly[LANE_SHIFT-1:0]};
`endif

endmodule
